// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//
// Operands are converted to magnitudes at acceptance, multiplied unsigned
// STEP_BITS multiplier bits per cycle into a 2*WORD_W accumulator, and the
// sign is restored when the DONE state is entered.
//
// Ports:
//   clk     in   rising-edge clock
//   nrst    in   asynchronous active-low reset
//   start   in   request; a, b, funct3 sampled when accepted (IDLE or DONE)
//   flush   in   abort in-flight op; wins over start in the same cycle
//   funct3  in   3'b000 MUL, 3'b001 MULH, 3'b010 MULHSU, 3'b011 MULHU
//                (other codes behave as MULHU)
//   a, b    in   rs1 / rs2 values
//   busy    out  high while in BUSY
//   done    out  one-cycle pulse in DONE; result valid
//   result  out  selected WORD_W bits of the product, held until next DONE
//
// Optional feature (compile-time macro MUL_EARLY_OUT_EN):
//   when defined, BUSY ends as soon as the remaining multiplier is zero,
//   giving data-dependent latency. When undefined, latency is fixed.

module mul_unit #(
  parameter int WORD_W    = 32,
  parameter int STEP_BITS = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
);

  localparam int N     = WORD_W / STEP_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * WORD_W;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [WORD_W-1:0]  mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               sel_lo;

  // Sum of the multiplicand shifted by each set bit of one multiplier digit.
  function automatic logic [ACC_W-1:0] partial_product(
    input logic [ACC_W-1:0]     m,
    input logic [STEP_BITS-1:0] d
  );
    logic [ACC_W-1:0] p;
    p = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (d[i]) p = p + (m << i);
    end
    return p;
  endfunction

  // Restore the sign of the magnitude product and pick the requested half.
  function automatic logic [WORD_W-1:0] finalize(
    input logic [ACC_W-1:0] mag,
    input logic             is_neg,
    input logic             lo_half
  );
    logic signed [ACC_W-1:0] prod;
    prod = is_neg ? -$signed(mag) : $signed(mag);
    return lo_half ? prod[WORD_W-1:0] : prod[ACC_W-1:WORD_W];
  endfunction

  // Acceptance-time operand decode.
  logic              sa, sb;
  logic [WORD_W-1:0] mag_a, mag_b;

  always_comb begin
    sa    = a[WORD_W-1] & ((funct3 == F3_MULH) | (funct3 == F3_MULHSU));
    sb    = b[WORD_W-1] & (funct3 == F3_MULH);
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One BUSY step.
  logic [ACC_W-1:0]  acc_nxt;
  logic [WORD_W-1:0] mplier_nxt;
  logic              last_step;

  always_comb begin
    acc_nxt    = acc + partial_product(mcand, mplier[STEP_BITS-1:0]);
    mplier_nxt = mplier >> STEP_BITS;
`ifdef MUL_EARLY_OUT_EN
    last_step  = (cnt == CNT_W'(N - 1)) || (mplier_nxt == '0);
`else
    last_step  = (cnt == CNT_W'(N - 1));
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sel_lo <= 1'b0;
    end else if (flush) begin
      // In-flight work is simply abandoned; result keeps its last value.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << STEP_BITS;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= finalize(acc_nxt, neg, sel_lo);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            state  <= BUSY;
            busy   <= 1'b1;
            done   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= {{WORD_W{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= sa ^ sb;
            sel_lo <= (funct3 == F3_MUL);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;

`ifdef MUL_EARLY_OUT_EN
  localparam logic [31:0] LONG_B = 32'h8000_0005;
`else
  localparam logic [31:0] LONG_B = 32'd5;
`endif

  logic        clk;
  logic        nrst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;
  logic [31:0] last_result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mul_unit #(.WORD_W(32), .STEP_BITS(1)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from 64-bit arithmetic on extended operands.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (f)
      MUL:     begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      MULH:    begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      MULHSU:  begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
      default: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
    endcase
  endfunction

  // Number of BUSY cycles expected for an operation.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] y);
`ifdef MUL_EARLY_OUT_EN
    logic [31:0] m;
    int s;
    m = (f == MULH && y[31]) ? (~y + 32'd1) : y;
    s = 1;
    while (s < 32 && (m >> s) != 32'd0) s++;
    return s;
`else
    return (f == 3'b000 && y == 32'hDEAD_BEEF) ? 32 : 32;
`endif
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit wait_neg, input bit push);
    exp_t e;
    if (wait_neg) @(negedge clk);
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    if (push) begin
      e.res = model(f, x, y);
      e.lat = exp_lat(f, y);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int poke, input bit chk_after);
    exp_t e;
    int   c;
    bit   got;
    bit   busy_ok;
    c = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && c < 200) begin
      @(negedge clk);
      c++;
      if (c == poke) begin
        start = 1'b1; funct3 = MUL; a = 32'd100; b = 32'd100;
      end else if (c == poke + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_done: no done pulse within %0d cycles", name, c);
      return;
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_queue: done seen but no expected entry", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (c != e.lat + 1) begin
      failures++;
      $display("FAIL %s_latency: done in cycle %0d, expected cycle %0d", name, c, e.lat + 1);
    end
    checks++;
    if (result !== e.res) begin
      failures++;
      $display("FAIL %s_result: got %h expected %h", name, result, e.res);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: busy profile wrong (busy_ok=%0d busy_at_done=%b, expected 1/0)", name, busy_ok, busy);
    end
    last_result = e.res;
    if (chk_after) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s_after: busy=%b done=%b expected 0/0", name, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = MUL; a = '0; b = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0/0", busy, done);
    end
    last_result = 32'd0;
  endtask

  task automatic test_mul_basic();
    issue(MUL, 32'd7, 32'd6, 1'b1, 1'b1);
    wait_done("mul_7x6", 0, 1'b1);
  endtask

  task automatic test_signed();
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done("mulhu_ff", 0, 1'b1);
    issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done("mulh_ff", 0, 1'b1);
    issue(MUL,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done("mul_min", 0, 1'b1);
    issue(MULHSU, 32'hFFFF_FFFE, 32'd3,         1'b1, 1'b1); wait_done("mulhsu_neg", 0, 1'b1);
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1); wait_done("mulh_min", 0, 1'b1);
    issue(MULH,   32'h0000_1234, 32'hFFFF_FF00, 1'b1, 1'b1); wait_done("mulh_mixed", 0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] x, y;
    for (int i = 0; i < 6; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      issue(f, x, y, 1'b1, 1'b1);
      wait_done("random", 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    issue(MUL, 32'd3, 32'd4, 1'b1, 1'b1);
    wait_done("b2b_op1", 0, 1'b0);
    issue(MUL, 32'd9, 32'd9, 1'b0, 1'b1);
    wait_done("b2b_op2", 0, 1'b1);
    issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    wait_done("start_in_busy", 5, 1'b1);
  endtask

  task automatic test_flush();
    bit bad;
    issue(MUL, 32'd5, LONG_B, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre: busy=%b expected 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy=%b done=%b expected 0/0", busy, done);
    end
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_no_done: activity seen after flush, expected none");
    end
    checks++;
    if (result !== last_result) begin
      failures++;
      $display("FAIL flush_result: got %h expected %h", result, last_result);
    end
    // start and flush together in IDLE
    @(negedge clk);
    funct3 = MUL; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL start_flush_idle: left IDLE, expected busy=0 done=0");
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    issue(MUL, 32'd11, LONG_B, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
    end
    @(negedge clk);
    nrst = 1'b1;
    last_result = 32'd0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_no_done: activity after reset, expected none");
    end
  endtask

  task automatic test_early_out();
    issue(MUL, 32'd123, 32'd0, 1'b1, 1'b1);
    wait_done("early_b0", 0, 1'b1);
    issue(MUL, 32'd77, 32'd1, 1'b1, 1'b1);
    wait_done("early_b1", 0, 1'b1);
    issue(MULH, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("early_neg", 0, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul_basic();
    test_signed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_early_out();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
